scv_cart: RTL and testbench

// Super Cassette Vision cartridge slot: 128 KiB ROM image plus optional 8 KiB battery RAM, with bank mapping

---
 rtl/scv_pkg.sv | 22 ++
 rtl/scv_cart_spram.sv | 31 +++
 rtl/scv_cart.sv | 99 +++++++++
 tb/tb_scv_cart.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scv_pkg.sv
// ---------------------------------------------------------------------------
// scv_pkg
// Shared types for the Super Cassette Vision cartridge slot: the mapper
// (cartridge type) selector used by the cart, the system top and the loader.
// Also holds the fixed memory geometry of the slot.
// ---------------------------------------------------------------------------
package scv_pkg;

   typedef enum logic [2:0] {
      MAPPER_ROM8K        = 3'd0,
      MAPPER_ROM16K       = 3'd1,
      MAPPER_ROM32K       = 3'd2,
      MAPPER_ROM32K_RAM8K = 3'd3,
      MAPPER_ROM64K       = 3'd4,
      MAPPER_ROM128K      = 3'd5
   } mapper_t;

   localparam int ROM_AW = 17;   // 128 KiB ROM image
   localparam int RAM_AW = 13;   // 8 KiB battery RAM
   localparam int DW     = 8;

endpackage

// File: rtl/scv_cart_spram.sv
// ---------------------------------------------------------------------------
// scv_cart_spram
// Single-port synchronous RAM with registered read. A read in the same cycle
// as a write to the same address returns the old contents.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable
//   addr   in   AWIDTH word address (shared by read and write)
//   wdata  in   DWIDTH write data
//   q      out  DWIDTH registered read data
// ---------------------------------------------------------------------------
module scv_cart_spram #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 13
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AWIDTH-1:0] addr,
   input  logic [DWIDTH-1:0] wdata,
   output logic [DWIDTH-1:0] q
);

   logic [DWIDTH-1:0] mem [0:(2**AWIDTH)-1];

   // No reset on contents or read register: memory content survives reset.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      q <= mem[addr];
   end

endmodule

// File: rtl/scv_cart.sv
// ---------------------------------------------------------------------------
// scv_cart
// Super Cassette Vision cartridge slot: 128 KiB ROM plus optional 8 KiB
// battery RAM on the upper 32 KiB of the CPU bus, banked by MAPPER and the
// CPU port C bits PC6/PC5. The ROM is filled through a byte-wide init port.
// Ports:
//   CLK, RES                       clock / async active-high reset
//   INIT_SEL, INIT_ADDR,
//   INIT_DATA, INIT_VALID          ROM load port (write when SEL & VALID)
//   MAPPER                         cartridge type
//   A, DB_I, CSB, RDB, WRB         CPU bus (A is CPU A[14:0], strobes low)
//   PC                             {PC6, PC5}
//   DB_O, DB_OE                    read data and its drive enable
// ---------------------------------------------------------------------------
module scv_cart
   import scv_pkg::*;
(
   input  logic          CLK,
   input  logic          RES,
   input  logic          INIT_SEL,
   input  logic [16:0]   INIT_ADDR,
   input  logic [7:0]    INIT_DATA,
   input  logic          INIT_VALID,
   input  mapper_t       MAPPER,
   input  logic [14:0]   A,
   input  logic [7:0]    DB_I,
   output logic [7:0]    DB_O,
   output logic          DB_OE,
   input  logic          CSB,
   input  logic          RDB,
   input  logic          WRB,
   input  logic [1:0]    PC
);

   logic [ROM_AW-1:0] rom_a;
   logic [ROM_AW-1:0] rom_addr;
   logic [DW-1:0]     rom_q;
   logic [DW-1:0]     ram_q;
   logic              ram_sel;
   logic              ram_we;
   logic              init_we;
   logic              sel_q;      // which memory the registered data came from
   logic              out_clr;    // holds DB_O at zero from reset to first edge

   // Mapper address mux: small carts mirror across the 32 KiB window,
   // large carts take their upper bank bits from port C.
   always_comb begin
      rom_a = {2'b00, A};
      case (MAPPER)
         MAPPER_ROM8K:        rom_a = {4'b0000, A[12:0]};
         MAPPER_ROM16K:       rom_a = {3'b000, A[13:0]};
         MAPPER_ROM32K:       rom_a = {2'b00, A};
         MAPPER_ROM32K_RAM8K: rom_a = {2'b00, A};
         MAPPER_ROM64K:       rom_a = {1'b0, PC[0], A};
         MAPPER_ROM128K:      rom_a = {PC[1], PC[0], A};
         default:             rom_a = {2'b00, A};
      endcase
   end

   // RAM overlays the top 8 KiB only when PC5 is set on a RAM cart.
   assign ram_sel  = (MAPPER == MAPPER_ROM32K_RAM8K) & PC[0] & (A[14:13] == 2'b11);
   assign ram_we   = ~CSB & ~WRB & ram_sel;

   // The init port steals the ROM's single port while loading.
   assign init_we  = INIT_SEL & INIT_VALID;
   assign rom_addr = init_we ? INIT_ADDR : rom_a;

   scv_cart_spram #(.DWIDTH(DW), .AWIDTH(ROM_AW)) u_rom (
      .clk   (CLK),
      .we    (init_we),
      .addr  (rom_addr),
      .wdata (INIT_DATA),
      .q     (rom_q)
   );

   scv_cart_spram #(.DWIDTH(DW), .AWIDTH(RAM_AW)) u_ram (
      .clk   (CLK),
      .we    (ram_we),
      .addr  (A[12:0]),
      .wdata (DB_I),
      .q     (ram_q)
   );

   // The memories' own read registers form the single output stage; this
   // flop pair only steers the mux and gives the output an async clear.
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         out_clr <= 1'b1;
         sel_q   <= 1'b0;
      end else begin
         out_clr <= 1'b0;
         sel_q   <= ram_sel;
      end
   end

   assign DB_O  = out_clr ? 8'h00 : (sel_q ? ram_q : rom_q);
   assign DB_OE = ~RES & ~CSB & ~RDB;

endmodule

// File: tb/tb_scv_cart.sv
// ---------------------------------------------------------------------------
// tb_scv_cart
// Self-checking bench for scv_cart: a byte-array model of the cart tracks
// every ROM load and RAM write and predicts the registered read data each
// clock; a compare process checks DB_O/DB_OE every falling edge. Directed
// cases with literal expectations are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_scv_cart;
   import scv_pkg::*;

   logic        CLK = 1'b0;
   logic        RES = 1'b0;
   logic        INIT_SEL = 1'b0;
   logic [16:0] INIT_ADDR = '0;
   logic [7:0]  INIT_DATA = '0;
   logic        INIT_VALID = 1'b0;
   mapper_t     MAPPER = MAPPER_ROM32K;
   logic [14:0] A = '0;
   logic [7:0]  DB_I = '0;
   logic [7:0]  DB_O;
   logic        DB_OE;
   logic        CSB = 1'b1;
   logic        RDB = 1'b1;
   logic        WRB = 1'b1;
   logic [1:0]  PC = 2'b00;

   int n_cmp = 0;
   int n_bad = 0;

   scv_cart dut (
      .CLK(CLK), .RES(RES), .INIT_SEL(INIT_SEL), .INIT_ADDR(INIT_ADDR),
      .INIT_DATA(INIT_DATA), .INIT_VALID(INIT_VALID), .MAPPER(MAPPER),
      .A(A), .DB_I(DB_I), .DB_O(DB_O), .DB_OE(DB_OE), .CSB(CSB),
      .RDB(RDB), .WRB(WRB), .PC(PC)
   );

   always #5 CLK = ~CLK;

   // ---------------- behavioural model ----------------
   logic [7:0] rom_m [0:131071];
   bit         rom_k [0:131071];
   logic [7:0] ram_m [0:8191];
   bit         ram_k [0:8191];
   logic [7:0] exp_o = 8'h00;
   bit         exp_k = 1'b0;

   function automatic int rom_index(mapper_t m, int a, int pc);
      case (m)
         MAPPER_ROM8K:   return a % 8192;
         MAPPER_ROM16K:  return a % 16384;
         MAPPER_ROM64K:  return (pc % 2) * 32768 + a;
         MAPPER_ROM128K: return pc * 32768 + a;
         default:        return a;
      endcase
   endfunction

   always @(posedge CLK) begin
      int  ri;
      int  wi;
      bit  rs;
      rs = (MAPPER == MAPPER_ROM32K_RAM8K) && PC[0] && (A >= 15'h6000);
      ri = rom_index(MAPPER, int'(A), int'(PC));
      wi = int'(A) % 8192;
      if (RES) begin
         exp_o = 8'h00; exp_k = 1'b1;
      end else if (INIT_SEL && INIT_VALID) begin
         exp_k = 1'b0;   // ROM port is busy loading
      end else if (rs) begin
         exp_o = ram_m[wi]; exp_k = ram_k[wi];
      end else begin
         exp_o = rom_m[ri]; exp_k = rom_k[ri];
      end
      if (!CSB && !WRB && rs) begin
         ram_m[wi] = DB_I; ram_k[wi] = 1'b1;
      end
      if (INIT_SEL && INIT_VALID) begin
         rom_m[INIT_ADDR] = INIT_DATA; rom_k[INIT_ADDR] = 1'b1;
      end
   end

   always @(posedge RES) begin
      exp_o = 8'h00; exp_k = 1'b1;
   end

   // ---------------- compare process ----------------
   always @(negedge CLK) begin
      logic oe_exp;
      oe_exp = !RES && !CSB && !RDB;
      n_cmp++;
      if (DB_OE !== oe_exp) begin
         n_bad++;
         $display("FAIL cyc_oe t=%0t: DB_OE got %b want %b", $time, DB_OE, oe_exp);
      end
      if (RES || exp_k) begin
         n_cmp++;
         if (DB_O !== (RES ? 8'h00 : exp_o)) begin
            n_bad++;
            $display("FAIL cyc_do t=%0t: DB_O got %h want %h", $time, DB_O,
                     RES ? 8'h00 : exp_o);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic tick(int n);
      repeat (n) @(posedge CLK);
      #2;
   endtask

   task automatic lit(string nm, logic [7:0] d, logic oe, bit at_neg);
      if (at_neg) @(negedge CLK);
      n_cmp++;
      if (DB_O !== d) begin
         n_bad++; $display("FAIL %s DB_O: got %h want %h", nm, DB_O, d);
      end
      n_cmp++;
      if (DB_OE !== oe) begin
         n_bad++; $display("FAIL %s DB_OE: got %b want %b", nm, DB_OE, oe);
      end
      if (at_neg && exp_k) begin
         n_cmp++;
         if (exp_o !== d) begin
            n_bad++; $display("FAIL %s model: got %h want %h", nm, exp_o, d);
         end
      end
      if (at_neg) #2;
   endtask

   task automatic init_wr(int addr, logic [7:0] d);
      INIT_SEL = 1'b1; INIT_VALID = 1'b1;
      INIT_ADDR = 17'(addr); INIT_DATA = d;
      tick(1);
      INIT_SEL = 1'b0; INIT_VALID = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int bases [3];
      bases = '{32'h08000, 32'h10000, 32'h18000};
      #1 RES = 1'b1;
      lit("reset", 8'h00, 1'b0, 1'b1);

      // Load under reset: 32 KiB pattern plus the first 4 KiB of banks 1..3.
      tick(1);
      INIT_SEL = 1'b1; INIT_VALID = 1'b1;
      for (int i = 0; i < 32768; i++) begin
         INIT_ADDR = 17'(i);
         INIT_DATA = 8'(i) ^ 8'(i >> 8);
         tick(1);
      end
      for (int b = 0; b < 3; b++)
         for (int j = 0; j < 4096; j++) begin
            INIT_ADDR = 17'(bases[b] + j);
            INIT_DATA = 8'($urandom);
            tick(1);
         end
      INIT_SEL = 1'b0; INIT_VALID = 1'b0;
      init_wr(32'h18010, 8'h5A);
      init_wr(32'h08010, 8'h3C);
      RES = 1'b0;
      tick(1);

      // 32K cart, pattern read
      MAPPER = MAPPER_ROM32K; A = 15'h1234; CSB = 1'b0; RDB = 1'b0;
      tick(1);
      lit("rom32k", 8'h26, 1'b1, 1'b1);

      // 8K cart mirror, loaded at run time
      MAPPER = MAPPER_ROM8K; CSB = 1'b1; RDB = 1'b1;
      init_wr(5, 8'hA5);
      A = 15'h6005; CSB = 1'b0; RDB = 1'b0;
      tick(1);
      lit("rom8k_mirror", 8'hA5, 1'b1, 1'b1);
      CSB = 1'b1; #1;
      lit("csb_high", 8'hA5, 1'b0, 1'b0);
      CSB = 1'b0;

      // 128K banking via port C
      MAPPER = MAPPER_ROM128K; PC = 2'b11; A = 15'h0010;
      tick(1);
      lit("rom128k_b3", 8'h5A, 1'b1, 1'b1);
      PC = 2'b01;
      tick(1);
      lit("rom128k_b1", 8'h3C, 1'b1, 1'b1);

      // RAM cart write then read, then PC5 cleared -> ROM underneath
      MAPPER = MAPPER_ROM32K_RAM8K; PC = 2'b01; A = 15'h7F00; DB_I = 8'hC3;
      RDB = 1'b1; WRB = 1'b0;
      tick(2);
      WRB = 1'b1; RDB = 1'b0;
      tick(1);
      lit("ram_rd", 8'hC3, 1'b1, 1'b1);
      PC = 2'b00;
      tick(1);
      lit("ram_off_rom", 8'h7F, 1'b1, 1'b1);

      // Write into ROM space is ignored
      MAPPER = MAPPER_ROM32K; A = 15'h1000; DB_I = 8'hFF; RDB = 1'b1; WRB = 1'b0;
      tick(2);
      WRB = 1'b1; RDB = 1'b0;
      tick(1);
      lit("rom_wr_ign", 8'h10, 1'b1, 1'b1);

      // Reset mid-read, RAM survives
      MAPPER = MAPPER_ROM32K_RAM8K; PC = 2'b01; A = 15'h7F00;
      tick(1);
      lit("pre_res", 8'hC3, 1'b1, 1'b1);
      RES = 1'b1; #1;
      lit("res_async", 8'h00, 1'b0, 1'b0);
      tick(1);
      RES = 1'b0;
      tick(1);
      lit("post_res_ram", 8'hC3, 1'b1, 1'b1);

      // Randomized traffic
      repeat (3000) begin
         int mk;
         mk = $urandom_range(0, 5);
         MAPPER = mapper_t'(mk);
         PC   = 2'($urandom);
         CSB  = ($urandom_range(0, 3) == 0);
         RDB  = 1'($urandom);
         WRB  = ($urandom_range(0, 2) != 0);
         DB_I = 8'($urandom);
         if (mk >= 4)
            A = 15'($urandom_range(0, 4095));
         else if (mk == 3 && $urandom_range(0, 1) == 1)
            A = {2'b11, 13'($urandom_range(0, 63))};
         else
            A = 15'($urandom);
         RES = ($urandom_range(0, 99) == 0);
         tick(1);
      end
      RES = 1'b0; CSB = 1'b1; RDB = 1'b1; WRB = 1'b1;
      tick(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
